// File: rtl/ps2_host_tx.sv
// ps2_host_tx - PS/2 host-to-device command transmitter (clk28 domain).
//
// Sends one byte (e.g. 0xED LED set, 0xFF reset, 0xF3 typematic) to the
// device on the shared open-drain ps2_clk/ps2_dat pair. While it owns the bus
// it raises rx_inhibit so the companion receiver drops whatever it sees.
//
// Ports:
//   clk28, rst            system clock, synchronous active-high reset
//   tx_data, tx_valid     byte to send and send request
//   tx_ready              idle, a byte is accepted on tx_valid & tx_ready
//   busy, rx_inhibit      high while a transaction is in progress
//   done                  1-cycle pulse: device ACKed and the bus is idle again
//   error                 1-cycle pulse: NACK or timeout
//   ps2_clk_in/ps2_dat_in raw asynchronous line levels
//   ps2_clk_oe/ps2_dat_oe 1 pulls the line low, 0 releases it
//
// Build option: define PS2_HOST_TX_RETRY_EN to retry a failed transfer up to
// two more times with the same latched byte before error is pulsed.

module ps2_host_tx #(
  parameter int unsigned CLK_FREQ          = 28_000_000,
  parameter int unsigned INHIBIT_US        = 120,
  parameter int unsigned START_TIMEOUT_US  = 15000,
  parameter int unsigned PACKET_TIMEOUT_US = 2000,
  parameter int unsigned FILTER_LEN        = 8
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned CYC_PER_US  = CLK_FREQ / 1_000_000;
  localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int unsigned START_CYC   = CYC_PER_US * START_TIMEOUT_US;
  localparam int unsigned PACKET_CYC  = CYC_PER_US * PACKET_TIMEOUT_US;
  localparam int unsigned MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int unsigned MAX_CYC     = (MAX_A > PACKET_CYC) ? MAX_A : PACKET_CYC;
  localparam int unsigned TMR_W       = $clog2(MAX_CYC + 1);
  localparam int unsigned FLT_W       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  // The clock is held low for INHIBIT_CYC cycles in total: INHIBIT_CYC-1
  // cycles in INHIBIT plus the single RTS cycle.
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYC - 2);
  localparam logic [TMR_W-1:0] START_LOAD   = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] PACKET_LOAD  = TMR_W'(PACKET_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE,
    FAIL
  } state_t;

  state_t           state, state_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic [9:0]       frame, frame_d;
  logic [9:0]       shift, shift_d;
  logic [3:0]       bitcnt, bitcnt_d;
  logic             dat_q, dat_d;
  logic             done_d, err_d;
  logic             clk_oe_d, dat_oe_d;
  logic             tmo, fall, last_try;

  // Index 0 = clock line, index 1 = data line.
  logic [1:0]       sync_a, sync_b, filt;
  logic [FLT_W-1:0] fcnt [2];
  logic             clk_prev;

`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] attempt, attempt_d;
`endif

  // Input conditioning: 2-FF synchronizer, then a filter that only follows
  // the line after FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk28) begin
    if (rst) begin
      sync_a   <= '1;
      sync_b   <= '1;
      filt     <= '1;
      fcnt     <= '{default: '0};
      clk_prev <= 1'b1;
    end else begin
      sync_a   <= {ps2_dat_in, ps2_clk_in};
      sync_b   <= sync_a;
      clk_prev <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_W'(FILTER_LEN - 1)) begin
          filt[i] <= sync_b[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev & ~filt[0];
  assign tmo  = (timer == '0);

`ifdef PS2_HOST_TX_RETRY_EN
  assign last_try = (attempt == 2'd2);
`else
  assign last_try = 1'b1;
`endif

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign rx_inhibit = (state != IDLE);

  always_comb begin
    state_d  = state;
    timer_d  = timer;
    frame_d  = frame;
    shift_d  = shift;
    bitcnt_d = bitcnt;
    dat_d    = dat_q;
    done_d   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    attempt_d = attempt;
`endif

    case (state)
      IDLE: begin
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          timer_d = INHIBIT_LOAD;
          state_d = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          attempt_d = '0;
`endif
        end
      end
      INHIBIT: begin
        if (tmo) state_d = RTS;
        else     timer_d = timer - TMR_W'(1);
      end
      RTS: begin
        state_d  = SEND;
        timer_d  = START_LOAD;
        shift_d  = frame;
        bitcnt_d = '0;
        dat_d    = 1'b1;  // start bit
      end
      SEND: begin
        // A timeout on the same cycle as a falling edge takes priority.
        if (tmo) begin
          state_d = FAIL;
        end else begin
          timer_d = timer - TMR_W'(1);
          if (fall) begin
            dat_d   = ~shift[0];
            shift_d = shift >> 1;
            if (bitcnt == 4'd0) timer_d = PACKET_LOAD;
            if (bitcnt == 4'd9) state_d  = ACK;
            else                bitcnt_d = bitcnt + 4'd1;
          end
        end
      end
      ACK: begin
        if (tmo) begin
          state_d = FAIL;
        end else begin
          timer_d = timer - TMR_W'(1);
          if (fall) state_d = filt[1] ? FAIL : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (tmo) begin
          state_d = FAIL;
        end else begin
          timer_d = timer - TMR_W'(1);
          if (&filt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      FAIL: begin
`ifdef PS2_HOST_TX_RETRY_EN
        if (!last_try) begin
          attempt_d = attempt + 2'd1;
          timer_d   = INHIBIT_LOAD;
          state_d   = INHIBIT;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (state_d != SEND) dat_d = 1'b0;

    // Line drives and pulses are registered from the next-state values so
    // the open-drain enables come straight from flops.
    clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
    dat_oe_d = ((state_d == INHIBIT) && (timer_d == '0)) ||
               (state_d == RTS) || ((state_d == SEND) && dat_d);
    err_d    = (state_d == FAIL) && last_try;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      frame      <= '0;
      shift      <= '0;
      bitcnt     <= '0;
      dat_q      <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      attempt    <= '0;
`endif
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      frame      <= frame_d;
      shift      <= shift_d;
      bitcnt     <= bitcnt_d;
      dat_q      <= dat_d;
      done       <= done_d;
      error      <= err_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
      attempt    <= attempt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx - bench for ps2_host_tx with a behavioural PS/2 device on
// the wired-AND lines. Timing parameters are scaled down so the timeouts fit
// in a short run; expected cycle counts are derived from the same values.

module tb_ps2_host_tx;

  localparam int unsigned CLK_FREQ   = 2_000_000;
  localparam int unsigned INHIBIT_US = 20;
  localparam int unsigned START_US   = 300;
  localparam int unsigned PACKET_US  = 500;
  localparam int unsigned FLT_LEN    = 8;
  localparam int CPU        = CLK_FREQ / 1_000_000;
  localparam int INH_CYC    = CPU * INHIBIT_US;
  localparam int START_CYC  = CPU * START_US;
  localparam int PACKET_CYC = CPU * PACKET_US;
  localparam int HALF       = 20;   // device clock half period, in clk28 cycles
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  localparam int M_ACK = 0, M_NACK = 1, M_NOCLK = 2, M_STOP5 = 3, M_GLITCH = 4;

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  logic       clk28 = 1'b0;
  logic       rst, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, error, rx_inhibit;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US), .START_TIMEOUT_US(START_US),
    .PACKET_TIMEOUT_US(PACKET_US), .FILTER_LEN(FLT_LEN)
  ) dut (
    .clk28(clk28), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error),
    .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk28 = ~clk28;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the 11 bits the device sees on the wire, start bit first.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // Event monitor, sampled on the falling edge of clk28.
  int cyc = 0, run = 0, both_cnt = 0, long_pulse = 0, own_bad = 0;
  int runs[$], send_cyc[$], datfall[$], done_q[$], err_q[$];
  logic pd = 1'b0, pe = 1'b0, pdat = 1'b0;

  always @(negedge clk28) begin
    cyc++;
    if (ps2_clk_oe === 1'b1) run++;
    else if (run != 0) begin
      runs.push_back(run);
      send_cyc.push_back(cyc);
      run = 0;
    end
    if (pdat === 1'b1 && ps2_dat_oe === 1'b0) datfall.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    if (error === 1'b1) err_q.push_back(cyc);
    if (done === 1'b1 && error === 1'b1) both_cnt++;
    if ((done === 1'b1 && pd === 1'b1) || (error === 1'b1 && pe === 1'b1)) long_pulse++;
    if (ps2_clk_oe === 1'b1 && busy !== 1'b1) own_bad++;
    if (ps2_dat_oe === 1'b1 && tx_ready === 1'b1) own_bad++;
    pd = done;
    pe = error;
    pdat = ps2_dat_oe;
  end

  task automatic clear_events();
    runs.delete(); send_cyc.delete(); datfall.delete(); done_q.delete(); err_q.delete();
  endtask

  // One device clock: high phase (optionally with a 3-cycle low glitch),
  // sample data as the clock is pulled low, then the low phase.
  task automatic dev_pulse(input bit glitch, output logic smp);
    if (glitch) begin
      repeat (HALF - 8) @(negedge clk28);
      dev_clk_low = 1'b1;
      repeat (3) @(negedge clk28);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk28);
    end else begin
      repeat (HALF) @(negedge clk28);
    end
    smp = ps2_dat_in;
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk28);
    dev_clk_low = 1'b0;
  endtask

  task automatic wait_send(input int n);
    int t = 0;
    while (send_cyc.size() <= n && t < START_CYC + PACKET_CYC + 4 * INH_CYC) begin
      @(negedge clk28);
      t++;
    end
  endtask

  task automatic run_case(input vec_t v);
    int n_att, t, ff, act;
    logic [10:0] fr;
    logic s;
    n_att = (v.mode == M_ACK || v.mode == M_GLITCH) ? 1 : ATTEMPTS;
    fr = frame_of(v.data);
    clear_events();
    tx_data = v.data;
    tx_valid = 1'b1;
    @(negedge clk28);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    check("accept_tx_ready", tx_ready, 0);
    check("accept_busy_inhibit", {busy, rx_inhibit}, 2'b11);
    for (int a = 0; a < n_att; a++) begin
      wait_send(a);
      check("send_entry", send_cyc.size() > a, 1);
      if (send_cyc.size() <= a) break;
      if (v.mode == M_ACK || v.mode == M_NACK || v.mode == M_GLITCH) begin
        for (int i = 0; i < 10; i++) begin
          dev_pulse(v.mode == M_GLITCH && i > 0, s);
          check($sformatf("bit%0d_%02h", i, v.data), s, fr[i]);
          if (i == 9) check("parity_table", s, v.exp_par);
        end
        check("stop_bit", ps2_dat_in, fr[10]);
        dev_dat_low = (v.mode != M_NACK);
        dev_pulse(1'b0, s);
        repeat (4) @(negedge clk28);
        dev_dat_low = 1'b0;
      end else if (v.mode == M_STOP5) begin
        for (int i = 0; i < 5; i++) begin
          dev_pulse(1'b0, s);
          check($sformatf("stop5_bit%0d", i), s, fr[i]);
          if (i == 2 && a == 0) begin
            tx_data = ~v.data;
            tx_valid = 1'b1;
            @(negedge clk28);
            tx_valid = 1'b0;
          end
        end
      end
    end
    t = 0;
    while (tx_ready !== 1'b1 && t < START_CYC + PACKET_CYC) begin
      @(negedge clk28);
      t++;
    end
    check("return_idle", tx_ready, 1);
    repeat (20) @(negedge clk28);
    check("inhibit_count", runs.size(), n_att);
    foreach (runs[k]) check("inhibit_len", runs[k], INH_CYC);
    check("done_pulses", done_q.size(), v.exp_done);
    check("error_pulses", err_q.size(), v.exp_err);
    check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    if (v.mode == M_NOCLK) begin
      act = (err_q.size() > 0 && send_cyc.size() >= n_att) ? err_q[0] - send_cyc[n_att-1] : -1;
      check("start_timeout", act, START_CYC);
    end
    if (v.mode == M_STOP5) begin
      ff = -1;
      foreach (datfall[k])
        if (ff < 0 && send_cyc.size() >= n_att && datfall[k] > send_cyc[n_att-1]) ff = datfall[k];
      act = (err_q.size() > 0 && ff >= 0) ? err_q[0] - ff : -1;
      check("packet_timeout", act, PACKET_CYC);
    end
  endtask

  vec_t vecs [13];

  initial begin
    logic s;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (4) @(negedge clk28);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_inhibit", rx_inhibit, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk28);

    vecs[0]  = '{8'hED, M_ACK,    1'b1, 1, 0};
    vecs[1]  = '{8'h00, M_ACK,    1'b1, 1, 0};
    vecs[2]  = '{8'h01, M_ACK,    1'b0, 1, 0};
    vecs[3]  = '{8'hFF, M_ACK,    1'b1, 1, 0};
    vecs[8]  = '{8'h3C, M_GLITCH, 1'b1, 1, 0};
    vecs[10] = '{8'h96, M_NACK,   1'b1, 0, 1};
    vecs[11] = '{8'hA5, M_STOP5,  1'b1, 0, 1};
    vecs[12] = '{8'h42, M_NOCLK,  1'b1, 0, 1};
    for (int i = 4; i < 8; i++) begin
      vecs[i].data = 8'($urandom);
      vecs[i].mode = M_ACK;
      vecs[i].exp_par = frame_of(vecs[i].data)[9];
      vecs[i].exp_done = 1;
      vecs[i].exp_err = 0;
    end
    vecs[9].data = 8'($urandom);
    vecs[9].mode = M_GLITCH;
    vecs[9].exp_par = frame_of(vecs[9].data)[9];
    vecs[9].exp_done = 1;
    vecs[9].exp_err = 0;

    for (int i = 0; i < 13; i++) run_case(vecs[i]);

    // Reset in the middle of SEND: lines released next cycle, no pulses.
    clear_events();
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk28);
    tx_valid = 1'b0;
    wait_send(0);
    check("rst_test_send_entry", send_cyc.size(), 1);
    for (int i = 0; i < 3; i++) dev_pulse(1'b0, s);
    repeat (5) @(negedge clk28);
    check("pre_rst_dat_oe", ps2_dat_oe, 1);
    rst = 1'b1;
    @(negedge clk28);
    check("mid_rst_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("mid_rst_flags", {tx_ready, busy, rx_inhibit, done, error}, 5'b10000);
    rst = 1'b0;
    repeat (100) @(negedge clk28);
    check("mid_rst_no_pulses", done_q.size() + err_q.size(), 0);

    // Resend after reset.
    run_case('{8'h5A, M_ACK, 1'b1, 1, 0});

    check("done_error_overlap", both_cnt, 0);
    check("pulse_width", long_pulse, 0);
    check("line_ownership", own_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
